// File: rtl/rgbw_scale_seq_pkg.sv
// Shared types and constants for the RGBW intensity scaling sequencer.
// The timeout feature of the top module is enabled by RGBW_SCALE_TIMEOUT_EN.
package rgbw_scale_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPTURE,
        RELEASE,
        NEXT,
        FINISH
    } state_t;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;
    localparam logic [1:0] CH_W = 2'd3;

    localparam logic [7:0] INTENSITY_OFF  = 8'h00;
    localparam logic [7:0] INTENSITY_FULL = 8'hFF;

endpackage

// File: rtl/rgbw_scale_seq.sv
// Scales a snapshotted RGBW colour by an intensity through a shared 8x8 multiplier
// (ld/rdy handshake). Define RGBW_SCALE_TIMEOUT_EN to abort on a missing mult_rdy.
//
// state   | meaning
// IDLE    | wait for start rising edge, snapshot inputs
// LOAD    | mult_ld high, operands stable, wait for mult_rdy
// CAPTURE | mult_ld low, latch rounded high byte into shadow
// RELEASE | wait for mult_rdy low and the ld gap to expire
// NEXT    | advance channel or finish after W
// FINISH  | publish shadow to outputs, pulse done
module rgbw_scale_seq
    import rgbw_scale_seq_pkg::*;
#(
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [7:0]  i_r_in,
    input  logic [7:0]  i_g_in,
    input  logic [7:0]  i_b_in,
    input  logic [7:0]  i_w_in,
    input  logic [7:0]  i_intensity,
    output logic        o_mult_ld,
    output logic [7:0]  o_mult_a,
    output logic [7:0]  o_mult_b,
    input  logic        i_mult_rdy,
    input  logic [15:0] i_mult_result,
    output logic [7:0]  o_r_out,
    output logic [7:0]  o_g_out,
    output logic [7:0]  o_b_out,
    output logic [7:0]  o_w_out,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    state_t             r_state;
    logic [1:0]         r_ch;
    logic [7:0]         r_snap [4];
    logic [7:0]         r_snap_k;
    logic [7:0]         r_shadow [4];
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_start_d;
    logic               r_mult_ld;
    logic [7:0]         r_mult_a;
    logic [7:0]         r_mult_b;
    logic [7:0]         r_out [4];
    logic               r_busy;
    logic               r_done;

    logic               w_start_rise;
    logic [1:0]         w_next_ch;
    logic [7:0]         w_rounded;
    logic               w_unused_lsbs;

    assign w_start_rise  = i_start & ~r_start_d;
    assign w_next_ch     = r_ch + 2'd1;
    // Round half up: only bit 7 of the low byte matters.
    assign w_rounded     = i_mult_result[15:8] + {7'd0, i_mult_result[7]};
    assign w_unused_lsbs = ^i_mult_result[6:0];

`ifdef RGBW_SCALE_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]    r_to_cnt;
    logic               r_err;
    assign o_err = r_err;
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign o_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ch      <= CH_R;
            r_snap_k  <= 8'h00;
            r_gap_cnt <= '0;
            r_start_d <= 1'b0;
            r_mult_ld <= 1'b0;
            r_mult_a  <= 8'h00;
            r_mult_b  <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_snap[k]   <= 8'h00;
                r_shadow[k] <= 8'h00;
                r_out[k]    <= 8'h00;
            end
`ifdef RGBW_SCALE_TIMEOUT_EN
            r_to_cnt  <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_start_d <= i_start;
            r_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_rise) begin
                        r_snap[CH_R] <= i_r_in;
                        r_snap[CH_G] <= i_g_in;
                        r_snap[CH_B] <= i_b_in;
                        r_snap[CH_W] <= i_w_in;
                        r_snap_k     <= i_intensity;
                        r_ch         <= CH_R;
                        r_busy       <= 1'b1;
`ifdef RGBW_SCALE_TIMEOUT_EN
                        r_err        <= 1'b0;
                        r_to_cnt     <= TO_W'(TIMEOUT_CYCLES - 1);
`endif
                        if (i_intensity == INTENSITY_OFF) begin
                            for (int k = 0; k < 4; k++) r_shadow[k] <= 8'h00;
                            r_state <= FINISH;
                        end else if (i_intensity == INTENSITY_FULL) begin
                            r_shadow[CH_R] <= i_r_in;
                            r_shadow[CH_G] <= i_g_in;
                            r_shadow[CH_B] <= i_b_in;
                            r_shadow[CH_W] <= i_w_in;
                            r_state        <= FINISH;
                        end else begin
                            r_mult_ld <= 1'b1;
                            r_mult_a  <= i_r_in;
                            r_mult_b  <= i_intensity;
                            r_state   <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (i_mult_rdy) begin
                        r_mult_ld <= 1'b0;
                        r_state   <= CAPTURE;
                    end
`ifdef RGBW_SCALE_TIMEOUT_EN
                    else if (r_to_cnt == '0) begin
                        r_mult_ld <= 1'b0;
                        r_err     <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt - TO_W'(1);
                    end
`endif
                end
                CAPTURE: begin
                    r_shadow[r_ch] <= w_rounded;
                    r_gap_cnt      <= GAP_W'(GAP_CYCLES - 1);
                    r_state        <= RELEASE;
                end
                RELEASE: begin
                    if (r_gap_cnt != '0) begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end else if (!i_mult_rdy) begin
                        r_state <= NEXT;
                    end
                end
                NEXT: begin
                    if (r_ch == CH_W) begin
                        r_state <= FINISH;
                    end else begin
                        r_ch      <= w_next_ch;
                        r_mult_ld <= 1'b1;
                        r_mult_a  <= r_snap[w_next_ch];
                        r_mult_b  <= r_snap_k;
`ifdef RGBW_SCALE_TIMEOUT_EN
                        r_to_cnt  <= TO_W'(TIMEOUT_CYCLES - 1);
`endif
                        r_state   <= LOAD;
                    end
                end
                FINISH: begin
                    for (int k = 0; k < 4; k++) r_out[k] <= r_shadow[k];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_mult_ld <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign o_mult_ld = r_mult_ld;
    assign o_mult_a  = r_mult_a;
    assign o_mult_b  = r_mult_b;
    assign o_r_out   = r_out[CH_R];
    assign o_g_out   = r_out[CH_G];
    assign o_b_out   = r_out[CH_B];
    assign o_w_out   = r_out[CH_W];
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: doc/rgbw_scale_seq.md
# rgbw_scale_seq

Initiator for the shared 8x8 multiplier's `ld`/`mult_rdy` handshake. On `start` it snapshots an RGBW colour and an 8-bit intensity. It then issues four sequential multiplications (R, G, B, W × intensity) through one multiplier instance and publishes the rounded high bytes atomically. It sits between the host register file and the PWM generators, upstream of the multiplier in the same parent.

## Interface
Parameters:
- `GAP_CYCLES`, default 2: minimum cycles `mult_ld` stays low between transactions (≥2, to cover the responder's 2-flop `ld` sampler).
- `TIMEOUT_CYCLES`, default 15: cycles to wait for `mult_rdy` before abort. Used only with the timeout feature.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: request a scale pass. Single-cycle or level; rising edge is detected.
- `r_in`, `g_in`, `b_in`, `w_in`, in, 8 each: colour channels.
- `intensity`, in, 8: scale factor (0x00 = off, 0xFF = unity).
- `mult_ld`, out, 1: load strobe to the multiplier.
- `mult_a`, `mult_b`, out, 8 each: operands (channel, intensity).
- `mult_rdy`, in, 1: multiplier result valid.
- `mult_result`, in, 16: multiplier product.
- `r_out`, `g_out`, `b_out`, `w_out`, out, 8 each: scaled channels.
- `busy`, out, 1: pass in progress.
- `done`, out, 1: one-cycle pulse when outputs update.
- `err`, out, 1: sticky timeout flag. Tied 0 when the feature is compiled out.

## Operation
- States:
  - IDLE
  - LOAD: `mult_ld`=1, operands held stable.
  - CAPTURE: latch result, `mult_ld`=0.
  - RELEASE: wait for `mult_rdy`=0 and gap counter ≥ `GAP_CYCLES`.
  - NEXT: channel index +1, or go to FINISH after W.
  - FINISH: copy shadow to outputs, pulse `done`.
- Channel order: R, G, B, W. The index is 2 bits; after W → FINISH, never wraps back to R within a pass.
- IDLE: on a `start` rising edge, snapshot all five inputs.
  - `intensity`=0x00: FINISH with shadow = 0, no transactions issued.
  - `intensity`=0xFF: FINISH with shadow = inputs, no transactions.
  - Otherwise: go to LOAD with channel R.
- LOAD: `mult_a`/`mult_b` are driven from the snapshot. Stay in LOAD until `mult_rdy`=1 is sampled, then go to CAPTURE.
- Arithmetic: shadow = `mult_result[15:8]` + `mult_result[7]` (round half up). The maximum non-bypass product is 254×255, so no overflow is possible; no saturation logic.
- RELEASE: if `mult_rdy` is still 1 (a stale value), keep waiting. The gap counter starts at CAPTURE.
- `start` while `busy`=1 is ignored; no queuing.
- Inputs changing mid-pass have no effect; only the snapshot is used.
- Outputs change only in FINISH, all four in the same cycle.
- Reset while active: next edge forces IDLE, `mult_ld`=0, all outputs 0, `err`=0.

## Timing
- Reset values: `mult_ld`=0, `mult_a`=0, `mult_b`=0, `r/g/b/w_out`=0, `busy`=0, `done`=0, `err`=0.
- `busy` rises the cycle after the `start` edge is detected and falls in the cycle `done` pulses.
- Bypass pass (intensity 0x00/0xFF): `done` 2 cycles after the `start` edge.
- Per-channel transaction: LOAD lasts until `mult_rdy` (responder latency 3–4 cycles), then CAPTURE 1 cycle, then RELEASE ≥ `GAP_CYCLES`.
- Full pass ≈ 4×(4+1+2)+2 ≈ 30 cycles.
- `mult_ld` never rises less than `GAP_CYCLES` cycles after its previous fall.

## Configuration
- `RGBW_SCALE_TIMEOUT_EN` defined:
  - A counter runs in LOAD.
  - If `mult_rdy` is not seen within `TIMEOUT_CYCLES`, drop `mult_ld`, set `err`=1, and go to IDLE. No `done`; outputs are retained.
  - `err` clears only on reset or on the next accepted `start`.
- Undefined: LOAD waits indefinitely; `err` is constant 0.

## Structure
- Shared package holds:
  - State enum (IDLE, LOAD, CAPTURE, RELEASE, NEXT, FINISH).
  - Channel index constants `CH_R`=0, `CH_G`=1, `CH_B`=2, `CH_W`=3.
  - `INTENSITY_OFF`=8'h00 and `INTENSITY_FULL`=8'hFF.
- No sub-module. The multiplier is instantiated beside this block in the parent, not inside it.

## Test plan
- R/G/B/W=200/1/16/255, intensity=128, behavioural responder with 4-cycle latency:
  - Outputs 100/1/8/128 (255×128=0x7F80 → 127+1=128).
  - Exactly 4 `mult_ld` pulses.
  - `done` once, `busy` low afterwards.
- intensity=0xFF, colours 0x12/0x34/0x56/0x78 → outputs equal inputs, zero `mult_ld` pulses, `done` 2 cycles after `start`.
- intensity=0x00 → all outputs 0, zero `mult_ld` pulses.
- `start` re-pulsed and inputs changed at cycle 10 of a pass → ignored; outputs reflect the original snapshot; one `done`.
- Reset asserted during the third LOAD → next cycle `mult_ld`=0, outputs 0, `busy`=0; a fresh pass afterwards completes correctly.
- With `RGBW_SCALE_TIMEOUT_EN`, responder never asserts `mult_rdy`:
  - After 15 LOAD cycles, `err`=1, `mult_ld`=0, no `done`.
  - The next `start` with a working responder clears `err`.
